// File: rtl/nexys_starship_shooter.sv
// Starship shooter core: aims at one of four sides, fires on BtnC, scores hits and misses,
// and enforces a fixed cooldown between accepted fires.
module nexys_starship_shooter #(
    parameter int COOL_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       game_over,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnC,
    input  logic       top_monster,
    input  logic       btm_monster,
    input  logic       left_monster,
    input  logic       right_monster,
    output logic       top_shot,
    output logic       btm_shot,
    output logic       left_shot,
    output logic       right_shot,
    output logic [1:0] aim_dir,
    output logic [7:0] kills,
    output logic [7:0] misses,
    output logic       q_Sh_Init,
    output logic       q_Sh_Ready,
    output logic       q_Sh_Cool,
    output logic       q_Sh_Done
);

    typedef enum logic [3:0] {
        S_INIT  = 4'b0001,
        S_READY = 4'b0010,
        S_COOL  = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOL_CYCLES - 1);

    localparam logic [1:0] AIM_TOP   = 2'b00;
    localparam logic [1:0] AIM_BTM   = 2'b01;
    localparam logic [1:0] AIM_LEFT  = 2'b10;
    localparam logic [1:0] AIM_RIGHT = 2'b11;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       r_aim;
    logic [1:0]       w_aim_next;
    logic [7:0]       r_kills;
    logic [7:0]       w_kills_next;
    logic [7:0]       r_misses;
    logic [7:0]       w_misses_next;
    logic [3:0]       r_shot;
    logic [3:0]       w_shot_next;
    logic [3:0]       w_monsters;
    logic             w_aim_live;

    // Bit order matches the aim_dir encoding so the aim can index it directly.
    assign w_monsters = {right_monster, left_monster, btm_monster, top_monster};
    assign w_aim_live = (r_state == S_READY) || (r_state == S_COOL);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_INIT;
            r_cnt    <= '0;
            r_aim    <= AIM_TOP;
            r_kills  <= 8'd0;
            r_misses <= 8'd0;
            r_shot   <= 4'b0000;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_aim    <= w_aim_next;
            r_kills  <= w_kills_next;
            r_misses <= w_misses_next;
            r_shot   <= w_shot_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_kills_next  = r_kills;
        w_misses_next = r_misses;
        w_shot_next   = 4'b0000;

        unique case (r_state)
            S_INIT: begin
                if (play_flag) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                if (game_over) begin
                    w_state_next = S_DONE;
                end else if (BtnC) begin
                    // The fire resolves against the aim held before this edge.
                    w_state_next = S_COOL;
                    w_cnt_next   = '0;
                    if (w_monsters[r_aim]) begin
                        w_shot_next[r_aim] = 1'b1;
                        if (r_kills != 8'hFF) begin
                            w_kills_next = r_kills + 8'd1;
                        end
                    end else if (r_misses != 8'hFF) begin
                        w_misses_next = r_misses + 8'd1;
                    end
                end
            end
            S_COOL: begin
                if (game_over) begin
                    w_state_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_READY;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (!play_flag) begin
                    w_state_next = S_INIT;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    always_comb begin
        w_aim_next = r_aim;
        if (w_aim_live) begin
            if (BtnU) begin
                w_aim_next = AIM_TOP;
            end else if (BtnD) begin
                w_aim_next = AIM_BTM;
            end else if (BtnL) begin
                w_aim_next = AIM_LEFT;
            end else if (BtnR) begin
                w_aim_next = AIM_RIGHT;
            end
        end
    end

    assign top_shot   = r_shot[0];
    assign btm_shot   = r_shot[1];
    assign left_shot  = r_shot[2];
    assign right_shot = r_shot[3];
    assign aim_dir    = r_aim;
    assign kills      = r_kills;
    assign misses     = r_misses;
    assign q_Sh_Init  = r_state[0];
    assign q_Sh_Ready = r_state[1];
    assign q_Sh_Cool  = r_state[2];
    assign q_Sh_Done  = r_state[3];

endmodule

// File: tb/tb_nexys_starship_shooter.sv
// Self-checking bench for nexys_starship_shooter: directed scenarios plus randomized play
// against a cycle-level behavioural model of the shooter rules.
module tb_nexys_starship_shooter;

    localparam int COOL = 4;

    logic       Clk;
    logic       Reset;
    logic       play_flag;
    logic       game_over;
    logic       BtnU, BtnD, BtnL, BtnR, BtnC;
    logic       top_monster, btm_monster, left_monster, right_monster;
    logic       top_shot, btm_shot, left_shot, right_shot;
    logic [1:0] aim_dir;
    logic [7:0] kills, misses;
    logic       q_Sh_Init, q_Sh_Ready, q_Sh_Cool, q_Sh_Done;

    logic [3:0] shots;
    logic [3:0] flags;
    assign shots = {right_shot, left_shot, btm_shot, top_shot};
    assign flags = {q_Sh_Done, q_Sh_Cool, q_Sh_Ready, q_Sh_Init};

    int total = 0;
    int bad   = 0;

    // Model: mode 0=INIT 1=READY 2=COOL 3=DONE; m_rem = cooldown edges still to wait.
    int         m_mode;
    int         m_aim;
    int         m_kills;
    int         m_misses;
    int         m_rem;
    logic [3:0] m_shot;

    nexys_starship_shooter #(
        .COOL_CYCLES(COOL),
        .CNT_W      (3)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .play_flag    (play_flag),
        .game_over    (game_over),
        .BtnU         (BtnU),
        .BtnD         (BtnD),
        .BtnL         (BtnL),
        .BtnR         (BtnR),
        .BtnC         (BtnC),
        .top_monster  (top_monster),
        .btm_monster  (btm_monster),
        .left_monster (left_monster),
        .right_monster(right_monster),
        .top_shot     (top_shot),
        .btm_shot     (btm_shot),
        .left_shot    (left_shot),
        .right_shot   (right_shot),
        .aim_dir      (aim_dir),
        .kills        (kills),
        .misses       (misses),
        .q_Sh_Init    (q_Sh_Init),
        .q_Sh_Ready   (q_Sh_Ready),
        .q_Sh_Cool    (q_Sh_Cool),
        .q_Sh_Done    (q_Sh_Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_mode   = 0;
        m_aim    = 0;
        m_kills  = 0;
        m_misses = 0;
        m_rem    = 0;
        m_shot   = 4'b0000;
    endfunction

    function automatic void model_step();
        logic [3:0] mon;
        int         old_mode;
        mon      = {right_monster, left_monster, btm_monster, top_monster};
        old_mode = m_mode;
        m_shot   = 4'b0000;
        case (m_mode)
            0: if (play_flag) m_mode = 1;
            1: begin
                if (game_over) m_mode = 3;
                else if (BtnC) begin
                    if (mon[m_aim]) begin
                        m_shot[m_aim] = 1'b1;
                        if (m_kills < 255) m_kills++;
                    end else if (m_misses < 255) begin
                        m_misses++;
                    end
                    m_mode = 2;
                    m_rem  = COOL;
                end
            end
            2: begin
                if (game_over) m_mode = 3;
                else begin
                    m_rem--;
                    if (m_rem == 0) m_mode = 1;
                end
            end
            default: if (!play_flag) m_mode = 0;
        endcase
        if (old_mode == 1 || old_mode == 2) begin
            if (BtnU) m_aim = 0;
            else if (BtnD) m_aim = 1;
            else if (BtnL) m_aim = 2;
            else if (BtnR) m_aim = 3;
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic clear_pulses();
        BtnU = 0; BtnD = 0; BtnL = 0; BtnR = 0; BtnC = 0;
    endtask

    task automatic set_monsters(input logic [3:0] m);
        {right_monster, left_monster, btm_monster, top_monster} = m;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (m_mode != 1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (q_Sh_Ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_ready: q_Sh_Ready=%b required=1 after %0d cycles", q_Sh_Ready, n);
        end
    endtask

    task automatic test_reset();
        Reset = 1; play_flag = 0; game_over = 0;
        clear_pulses();
        set_monsters(4'b0000);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 0;
        tick();
        total++;
        if (flags !== 4'b0001) begin
            bad++; $display("FAIL reset_state: flags=%b required=0001", flags);
        end
        total++;
        if ({aim_dir, kills, misses, shots} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: aim=%b kills=%0d misses=%0d shots=%b required all zero",
                     aim_dir, kills, misses, shots);
        end
        tick();
        total++;
        if (q_Sh_Init !== 1'b1) begin
            bad++; $display("FAIL reset_hold: q_Sh_Init=%b required=1 with play_flag=0", q_Sh_Init);
        end
        $display("test_reset: state=%b", flags);
    endtask

    task automatic test_first_kill();
        play_flag = 1;
        tick();
        total++;
        if (q_Sh_Ready !== 1'b1) begin
            bad++; $display("FAIL start_ready: q_Sh_Ready=%b required=1", q_Sh_Ready);
        end
        set_monsters(4'b0001);
        BtnC = 1;
        tick();
        BtnC = 0;
        total++;
        if (shots !== 4'b0001 || kills !== 8'd1 || q_Sh_Cool !== 1'b1) begin
            bad++;
            $display("FAIL first_kill: shots=%b kills=%0d cool=%b required shots=0001 kills=1 cool=1",
                     shots, kills, q_Sh_Cool);
        end
        tick();
        total++;
        if (shots !== 4'b0000) begin
            bad++; $display("FAIL shot_width: shots=%b required=0000", shots);
        end
        $display("test_first_kill: kills=%0d", kills);
    endtask

    task automatic test_miss_aim();
        wait_ready();
        BtnR = 1;
        tick();
        BtnR = 0;
        set_monsters(4'b0111);
        BtnC = 1;
        tick();
        BtnC = 0;
        total++;
        if (shots !== 4'b0000 || misses !== 8'd1 || aim_dir !== 2'b11) begin
            bad++;
            $display("FAIL miss_right: shots=%b misses=%0d aim=%b required shots=0000 misses=1 aim=11",
                     shots, misses, aim_dir);
        end
        $display("test_miss_aim: misses=%0d aim=%b", misses, aim_dir);
    endtask

    task automatic test_back_to_back();
        int first, second, nshots, k0;
        wait_ready();
        set_monsters(4'b1111);
        k0 = m_kills;
        first = -1; second = -1; nshots = 0;
        BtnC = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (shots != 4'b0000) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
                nshots++;
            end
        end
        BtnC = 0;
        total++;
        if (first != 0 || second - first != COOL + 1) begin
            bad++;
            $display("FAIL fire_spacing: first=%0d second=%0d required first=0 gap=%0d",
                     first, second, COOL + 1);
        end
        total++;
        if (nshots != 3 || int'(kills) != k0 + 3) begin
            bad++;
            $display("FAIL held_fire_count: shots=%0d kills=%0d required shots=3 kills=%0d",
                     nshots, kills, k0 + 3);
        end
        $display("test_back_to_back: gap=%0d kills=%0d", second - first, kills);
    endtask

    task automatic test_aim_priority();
        wait_ready();
        BtnU = 1; BtnL = 1;
        tick();
        clear_pulses();
        total++;
        if (aim_dir !== 2'b00) begin
            bad++; $display("FAIL aim_priority: aim=%b required=00", aim_dir);
        end
        wait_ready();
        set_monsters(4'b0001);
        BtnD = 1; BtnC = 1;
        tick();
        clear_pulses();
        total++;
        if (shots !== 4'b0001 || aim_dir !== 2'b01) begin
            bad++;
            $display("FAIL aim_with_fire: shots=%b aim=%b required shots=0001 aim=01", shots, aim_dir);
        end
        $display("test_aim_priority: aim=%b", aim_dir);
    endtask

    task automatic test_saturation_done();
        int k;
        BtnU = 1;
        wait_ready();
        tick();
        BtnU = 0;
        set_monsters(4'b0001);
        for (int i = 0; i < 256; i++) begin
            wait_ready();
            BtnC = 1;
            tick();
            BtnC = 0;
        end
        total++;
        if (kills !== 8'd255) begin
            bad++; $display("FAIL kills_saturate: kills=%0d required=255", kills);
        end
        wait_ready();
        BtnC = 1;
        tick();
        BtnC = 0;
        total++;
        if (kills !== 8'd255 || shots !== 4'b0001) begin
            bad++; $display("FAIL kills_hold: kills=%0d shots=%b required 255 0001", kills, shots);
        end
        tick();
        k = int'(misses);
        game_over = 1; BtnC = 1;
        tick();
        total++;
        if (q_Sh_Done !== 1'b1 || shots !== 4'b0000) begin
            bad++; $display("FAIL cool_to_done: done=%b shots=%b required done=1 shots=0000", q_Sh_Done, shots);
        end
        game_over = 0; BtnD = 1; set_monsters(4'b0000);
        tick();
        clear_pulses();
        total++;
        if (q_Sh_Done !== 1'b1 || shots !== 4'b0000 || aim_dir !== 2'b00 || int'(misses) != k) begin
            bad++;
            $display("FAIL done_frozen: done=%b shots=%b aim=%b misses=%0d required 1 0000 00 %0d",
                     q_Sh_Done, shots, aim_dir, misses, k);
        end
        play_flag = 0;
        tick();
        total++;
        if (q_Sh_Init !== 1'b1 || kills !== 8'd255) begin
            bad++; $display("FAIL done_to_init: init=%b kills=%0d required init=1 kills=255", q_Sh_Init, kills);
        end
        $display("test_saturation_done: kills=%0d state=%b", kills, flags);
    endtask

    task automatic test_async_reset();
        play_flag = 1;
        wait_ready();
        set_monsters(4'b0001);
        BtnC = 1;
        tick();
        BtnC = 0;
        #3;
        Reset = 1;
        #1;
        model_reset();
        total++;
        if (flags !== 4'b0001 || shots !== 4'b0000 || {aim_dir, kills, misses} !== 18'd0) begin
            bad++;
            $display("FAIL async_reset: flags=%b shots=%b aim=%b kills=%0d misses=%0d required 0001 0000 00 0 0",
                     flags, shots, aim_dir, kills, misses);
        end
        #2;
        Reset = 0;
        play_flag = 0;
        repeat (COOL + 2) tick();
        total++;
        if (q_Sh_Init !== 1'b1 || shots !== 4'b0000) begin
            bad++; $display("FAIL reset_release: init=%b shots=%b required 1 0000", q_Sh_Init, shots);
        end
        play_flag = 1;
        tick();
        total++;
        if (q_Sh_Ready !== 1'b1) begin
            bad++; $display("FAIL restart: ready=%b required=1", q_Sh_Ready);
        end
        $display("test_async_reset: state=%b", flags);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 1500; i++) begin
            BtnU = ($urandom_range(0, 5) == 0);
            BtnD = ($urandom_range(0, 5) == 0);
            BtnL = ($urandom_range(0, 5) == 0);
            BtnR = ($urandom_range(0, 5) == 0);
            BtnC = ($urandom_range(0, 2) == 0);
            set_monsters(4'($urandom));
            game_over = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 24) == 0) play_flag = ~play_flag;
            tick();
            total++;
            if (flags !== (4'b0001 << m_mode) || shots !== m_shot || aim_dir !== 2'(m_aim) ||
                kills !== 8'(m_kills) || misses !== 8'(m_misses)) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle %0d: flags=%b shots=%b aim=%0d kills=%0d misses=%0d required %b %b %0d %0d %0d",
                             i, flags, shots, aim_dir, kills, misses,
                             4'b0001 << m_mode, m_shot, m_aim, m_kills, m_misses);
            end
        end
        clear_pulses();
        game_over = 0;
        $display("test_random: kills=%0d misses=%0d", kills, misses);
    endtask

    initial begin
        test_reset();
        test_first_kill();
        test_miss_aim();
        test_back_to_back();
        test_aim_priority();
        test_saturation_done();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nexys_starship_shooter.md
NEXYS_STARSHIP_SHOOTER -- requirements
Module: nexys_starship_shooter

Interface
REQ-001 SHALL have parameter COOL_CYCLES, default 25000000, cooldown length in Clk cycles after each fire (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 25, cooldown counter width; it SHALL hold COOL_CYCLES-1.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port play_flag  input  1  game running; high starts play from INIT.
REQ-006 SHALL have port game_over  input  1  level; high ends play.
REQ-007 SHALL have ports BtnU, BtnD, BtnL, BtnR  input  1 each  debounced single-cycle aim pulses.
REQ-008 SHALL have port BtnC  input  1  debounced single-cycle fire pulse.
REQ-009 SHALL have ports top_monster, btm_monster, left_monster, right_monster  input  1 each  monster present at that side.
REQ-010 SHALL have ports top_shot, btm_shot, left_shot, right_shot  output  1 each  single-cycle kill pulse to that side's monster FSM.
REQ-011 SHALL have port aim_dir  output  2  current aim: 00 top, 01 bottom, 10 left, 11 right.
REQ-012 SHALL have ports kills, misses  output  8 each  saturating hit and miss counts.
REQ-013 SHALL have ports q_Sh_Init, q_Sh_Ready, q_Sh_Cool, q_Sh_Done  output  1 each  one-hot state flags.

Function
REQ-014 SHALL implement four one-hot states INIT, READY, COOL, DONE; illegal encodings SHALL go to INIT on the next edge.
REQ-015 INIT: SHALL go to READY on the edge where play_flag=1; no aim change, no shots, counters held.
REQ-016 READY: on the edge with BtnC=1, SHALL go to COOL and load the cooldown counter with 0.
REQ-017 READY, BtnC=1, monster present in aim_dir: SHALL assert exactly that side's *_shot for the one cycle following the edge, and increment kills.
REQ-018 READY, BtnC=1, no monster in aim_dir: SHALL assert no *_shot, increment misses.
REQ-019 Monster presence SHALL be sampled on the same edge as BtnC; later changes do not affect that fire.
REQ-020 COOL: counter SHALL increment each cycle; at value COOL_CYCLES-1, return to READY the next edge; BtnC ignored (no shot, no count).
REQ-021 Fire-to-next-acceptable-fire latency SHALL be exactly COOL_CYCLES+1 cycles.
REQ-022 Aim pulses SHALL update aim_dir in READY and COOL, not in INIT or DONE.
REQ-023 Simultaneous aim pulses: priority U > D > L > R.
REQ-024 Aim pulse and BtnC on the same edge: fire SHALL use the old aim_dir; new aim applies afterward.
REQ-025 kills and misses SHALL saturate at 255.
REQ-026 game_over=1 in READY or COOL SHALL go to DONE next edge, overriding BtnC; no shot pulses that edge.
REQ-027 DONE: outputs frozen except *_shot=0; return to INIT only when play_flag=0.
REQ-028 At most one *_shot high per cycle; all *_shot SHALL be registered outputs.

Reset
REQ-029 Reset=1 SHALL immediately force INIT, aim_dir=00, kills=0, misses=0, all *_shot=0, cooldown counter=0, regardless of clock.
REQ-030 Reset during COOL or during a shot pulse SHALL cancel it; no pulse after release.
REQ-031 After release, first transition SHALL need play_flag=1 sampled on a rising edge.

Verification (COOL_CYCLES=4)
REQ-032 Reset, play_flag=1, top_monster=1, BtnC pulse -> top_shot high 1 cycle, kills=1, q_Sh_Cool=1.
REQ-033 READY, BtnR then BtnC, right_monster=0 -> no shot, misses=1, aim_dir=11.
REQ-034 Fire, then BtnC every cycle -> second shot exactly 5 cycles after first; intermediate BtnC not counted.
REQ-035 BtnU and BtnL same cycle -> aim_dir=00; BtnD with BtnC, top_monster=1 -> top_shot, then aim_dir=01.
REQ-036 256 hits -> kills stays 255; game_over=1 mid-COOL -> DONE, BtnC ignored, play_flag=0 -> INIT.
REQ-037 Reset asserted mid-COOL between clock edges -> INIT and all outputs cleared immediately.
